lcd_fb_arbiter: RTL
===================

// Module: lcd_fb_arbiter
// PURPOSE
//  Owns the single-port RGB565 framebuffer RAM that feeds the SPI LCD scan engine. Arbitrates
//  each RAM cycle between three users:
//  - the scan reader, which has priority and needs a fixed-latency pixel;
//  - the drawing-engine writer, on a valid/ready handshake;
//  - an internal full-screen clear sequencer.
//  Sits between game/draw logic and the LCD driver's pixel-fetch port.
// PARAMETERS
//  FB_W         132  framebuffer width in pixels (x range 0..FB_W-1)
//  FB_H         162  framebuffer height in pixels (y range 0..FB_H-1)
//  ADDR_W       15   RAM address width; FB_W*FB_H must be <= 2**ADDR_W
//  DATA_W       16   pixel width (RGB565)
//  WR_MAX_WAIT  8    cycles a pending writer may be blocked before it is forced a slot
//  BG_COLOR     16'h0000  colour returned for out-of-range reads
// PORTS
//  clk          in   1       system clock (100 MHz)
//  rst_n        in   1       asynchronous, active-low reset
//  rd_valid     in   1       scan reader requests pixel at (rd_x, rd_y)
//  rd_ready     out  1       read accepted on this edge when rd_valid&rd_ready
//  rd_x, rd_y   in   8 each  read coordinates
//  rd_data      out  DATA_W  returned pixel
//  rd_data_vld  out  1       rd_data valid (one-cycle pulse per accepted read)
//  wr_valid     in   1       writer presents (wr_x, wr_y, wr_color)
//  wr_ready     out  1       write accepted on this edge when wr_valid&wr_ready
//  wr_x, wr_y   in   8 each  write coordinates
//  wr_color     in   DATA_W  write pixel
//  wr_err       out  1       one-cycle pulse: accepted write was out of range and dropped
//  clr_start    in   1       pulse: fill whole framebuffer with clr_color
//  clr_color    in   DATA_W  fill colour, sampled on accepted clr_start
//  clr_busy     out  1       clear in progress
//  clr_done     out  1       one-cycle pulse after the last clear write is issued
//  ram_addr     out  ADDR_W  RAM address (registered)
//  ram_we       out  1       RAM write enable (registered)
//  ram_wdata    out  DATA_W  RAM write data (registered)
//  ram_rdata    in   DATA_W  RAM read data; synchronous, 1-cycle latency
// BEHAVIOUR
//  - Reset: rd_data_vld=0, wr_err=0, clr_busy=0, clr_done=0, ram_we=0, ram_addr=0,
//    ram_wdata=0, wait counter=0, state=IDLE. Reset mid-clear aborts; RAM contents undefined.
//  - Address: addr = y*FB_W + x, computed in ADDR_W bits. In range iff x<FB_W and y<FB_H.
//  - States:
//    IDLE: arbitrate reader and writer. Accepted clr_start -> CLEAR next cycle,
//      clr_cnt=0, clr_color latched.
//    CLEAR: wr_ready=0. Each cycle not granted to the reader writes clr_color at clr_cnt and
//      increments clr_cnt. The write at clr_cnt=FB_W*FB_H-1 pulses clr_done on the next
//      cycle and returns to IDLE. clr_busy=1 throughout CLEAR.
//  - Grant per cycle, exactly one winner:
//    - Reader wins (rd_ready=1) unless the forced-writer slot is active.
//    - Writer wins (IDLE only) when there is no rd_valid, or when the forced slot is active.
//    - Forced slot: the wait counter counts cycles with wr_valid=1 && wr_ready=0. Counter
//      reaching WR_MAX_WAIT sets the forced slot for the following cycle: rd_ready=0,
//      wr_ready=1. Counter clears on a write accept.
//    - The clear sequencer only fills cycles the reader does not take; it never starves the
//      reader.
//  - Read latency: read accepted at edge k; ram_addr is registered at k; RAM samples at k+1;
//    rd_data_vld=1 and rd_data=ram_rdata during the cycle after k+1 (2 edges).
//    Out-of-range read: no RAM access needed; rd_data=BG_COLOR with the same 2-edge timing.
//    Back-to-back reads stream one pixel per cycle.
//  - Write: accepted at edge k -> ram_we=1 with ram_addr/ram_wdata during cycle k+1.
//    Out-of-range write: accepted, ram_we stays 0, wr_err pulses in cycle k+1.
//  - clr_start while clr_busy=1: ignored.
//  - clr_start in IDLE in the same cycle as a write handshake: the write completes normally
//    and the clear starts next cycle.
//  - rd_ready and wr_ready are combinational from state, counter and rd_valid only; they
//    never depend on wr_valid.
// STRUCTURE
//  - lcd_fb_pkg: FB_W/FB_H defaults, colour constants (BLACK, WHITE, YELLOW...), state
//    enum {IDLE, CLEAR}.
//  - Sub-module lcd_fb_addr: combinational (x,y) -> {in_range, addr}, instantiated twice
//    (read and write paths). The clear path uses clr_cnt directly.
// TESTING
//  1. Reset with rd_valid=1 held: no rd_data_vld for 2 edges after rst_n rises. Then read
//     (0,0) with RAM preloaded 16'h1234: rd_data=16'h1234, rd_data_vld exactly 2 edges later.
//  2. Writer (131,161,16'hF800) with idle reader: wr_ready=1, ram_we=1, ram_addr=21383.
//     (132,0): wr_err pulse, no ram_we.
//  3. rd_valid held high plus wr_valid pending: writer is forced in after exactly 8 blocked
//     cycles. rd_ready=0 for that one cycle only; the reader stream resumes next cycle.
//  4. clr_start with clr_color=16'hFFE0, no reader: 21384 writes to addresses 0..21383, then
//     clr_done pulse and clr_busy falls. Mid-clear wr_valid sees wr_ready=0 throughout.
//  5. Clear with the reader active 50% of cycles: every read still returns at 2-edge latency,
//     the clear completes, and a second clr_start during busy is ignored.
//  6. rst_n low mid-clear: clr_busy=0 and ram_we=0 immediately (asynchronously); the next
//     clr_start restarts the fill from address 0.

Source files
------------

// File: rtl/lcd_fb_pkg.sv
// Shared constants and types for the LCD framebuffer arbiter: geometry defaults,
// RGB565 colour constants and the arbiter state encoding.
package lcd_fb_pkg;

    localparam int FB_W_DEF        = 132;
    localparam int FB_H_DEF        = 162;
    localparam int ADDR_W_DEF      = 15;
    localparam int DATA_W_DEF      = 16;
    localparam int WR_MAX_WAIT_DEF = 8;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] MAGENTA = 16'hF81F;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

endpackage

// File: rtl/lcd_fb_addr.sv
// Combinational pixel-coordinate decoder: linear address y*FB_W + x plus an
// in-range flag. Shared by the read and write paths of the arbiter.
module lcd_fb_addr #(
    parameter int FB_W   = 132,
    parameter int FB_H   = 162,
    parameter int ADDR_W = 15
) (
    input  logic [7:0]        x_i,
    input  logic [7:0]        y_i,
    output logic              in_range_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [31:0]       W_LIM = FB_W;
    localparam logic [31:0]       H_LIM = FB_H;
    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(FB_W);

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    assign x_ext      = ADDR_W'(x_i);
    assign y_ext      = ADDR_W'(y_i);
    assign in_range_o = ({24'd0, x_i} < W_LIM) && ({24'd0, y_i} < H_LIM);
    assign addr_o     = (y_ext * W_A) + x_ext;

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Single-port RGB565 framebuffer arbiter: scan reader (priority, fixed 2-edge latency),
// drawing-engine writer (valid/ready with anti-starvation slot) and full-screen clear.
module lcd_fb_arbiter
    import lcd_fb_pkg::*;
#(
    parameter int                 FB_W        = FB_W_DEF,
    parameter int                 FB_H        = FB_H_DEF,
    parameter int                 ADDR_W      = ADDR_W_DEF,
    parameter int                 DATA_W      = DATA_W_DEF,
    parameter int                 WR_MAX_WAIT = WR_MAX_WAIT_DEF,
    parameter logic [DATA_W-1:0]  BG_COLOR    = DATA_W'(BLACK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid_i,
    output logic              rd_ready_o,
    input  logic [7:0]        rd_x_i,
    input  logic [7:0]        rd_y_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_data_vld_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [7:0]        wr_x_i,
    input  logic [7:0]        wr_y_i,
    input  logic [DATA_W-1:0] wr_color_i,
    output logic              wr_err_o,
    input  logic              clr_start_i,
    input  logic [DATA_W-1:0] clr_color_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int                CNT_W    = $clog2(WR_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_MAX = CNT_W'(WR_MAX_WAIT);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

    fb_state_e         state_q;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [DATA_W-1:0] clr_color_q;
    logic              rd_p1_q, rd_p1_oor_q;
    logic              rd_vld_q, rd_oor_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              wr_err_q;
    logic              clr_done_q;

    logic              rd_in_range, wr_in_range;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic              forced, rd_acc, wr_acc, clr_slot;

    lcd_fb_addr #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) u_rd_addr (
        .x_i        (rd_x_i),
        .y_i        (rd_y_i),
        .in_range_o (rd_in_range),
        .addr_o     (rd_addr)
    );

    lcd_fb_addr #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) u_wr_addr (
        .x_i        (wr_x_i),
        .y_i        (wr_y_i),
        .in_range_o (wr_in_range),
        .addr_o     (wr_addr)
    );

    // Ready signals deliberately ignore wr_valid so the writer never sees a combinational loop.
    assign forced     = (state_q == IDLE) && (wait_q >= WAIT_MAX);
    assign rd_ready_o = !forced;
    assign wr_ready_o = (state_q == IDLE) && (!rd_valid_i || forced);
    assign rd_acc     = rd_valid_i && rd_ready_o;
    assign wr_acc     = wr_valid_i && wr_ready_o;
    assign clr_slot   = (state_q == CLEAR) && !rd_acc;

    // Blocked-writer counter saturates so a long clear cannot wrap it.
    always_comb begin
        wait_d = wait_q;
        if (wr_acc) begin
            wait_d = '0;
        end else if (wr_valid_i && !wr_ready_o && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_p1_oor_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_oor_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            wr_err_q    <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            rd_p1_q     <= rd_acc;
            rd_p1_oor_q <= rd_acc && !rd_in_range;
            rd_vld_q    <= rd_p1_q;
            rd_oor_q    <= rd_p1_oor_q;
            ram_we_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            clr_done_q  <= 1'b0;

            if (rd_acc) begin
                if (rd_in_range) begin
                    ram_addr_q <= rd_addr;
                end
            end else if (wr_acc) begin
                if (wr_in_range) begin
                    ram_we_q    <= 1'b1;
                    ram_addr_q  <= wr_addr;
                    ram_wdata_q <= wr_color_i;
                end else begin
                    wr_err_q <= 1'b1;
                end
            end else if (clr_slot) begin
                ram_we_q    <= 1'b1;
                ram_addr_q  <= clr_cnt_q;
                ram_wdata_q <= clr_color_q;
                clr_cnt_q   <= clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    clr_done_q <= 1'b1;
                    state_q    <= IDLE;
                end
            end

            // A clear request only counts while idle; a concurrent write still completes above.
            if ((state_q == IDLE) && clr_start_i) begin
                state_q     <= CLEAR;
                clr_cnt_q   <= '0;
                clr_color_q <= clr_color_i;
            end
        end
    end

    assign rd_data_vld_o = rd_vld_q;
    assign rd_data_o     = rd_oor_q ? BG_COLOR : ram_rdata_i;
    assign wr_err_o      = wr_err_q;
    assign clr_busy_o    = (state_q == CLEAR);
    assign clr_done_o    = clr_done_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_we_o      = ram_we_q;
    assign ram_wdata_o   = ram_wdata_q;

endmodule
